// File: rtl/mcu_readback_port.sv
// MCU read-back port: lets the MCU set an X/Y pixel address and read the prefetched video byte.
// Define MCU_READBACK_STATUS_EN to expose {fetchBusy, dataValid} in register 5 (reads 0x00 otherwise).
module mcu_readback_port #(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mpuChipSelect,
  input  logic                  mpuWriteEnable,
  input  logic [2:0]            mpuRegisterSelect,
  input  logic [DATA_WIDTH-1:0] mpuDataIn,
  output logic [DATA_WIDTH-1:0] mpuDataOut,
  output logic                  mpuDataOutEnable,
  output logic [ADDR_WIDTH-1:0] memoryAddress,
  output logic                  memoryReadRequest,
  input  logic [DATA_WIDTH-1:0] memoryReadData,
  input  logic                  memoryReadComplete
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_e;

  logic write_strobe, read_strobe;
  logic wr_sync1_q, wr_sync2_q, wr_hist_q, wr_sync1_d, wr_sync2_d, wr_hist_d;
  logic rd_sync1_q, rd_sync2_q, rd_hist_q, rd_sync1_d, rd_sync2_d, rd_hist_d;
  logic wr_end, rd_end, addr_commit;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] read_addr_q, read_addr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] data_reg_q, data_reg_d;
  logic                  auto_inc_q, auto_inc_d;
  logic                  data_valid_q, data_valid_d;
  logic                  fetch_pending_q, fetch_pending_d;

  assign write_strobe = mpuChipSelect & ~mpuWriteEnable;
  assign read_strobe  = mpuChipSelect & mpuWriteEnable;

  // Strobes are asynchronous to clock; the history flop turns the synchronized level into an end pulse.
  always_comb begin
    wr_sync1_d = write_strobe;
    wr_sync2_d = wr_sync1_q;
    wr_hist_d  = wr_sync2_q;
    rd_sync1_d = read_strobe;
    rd_sync2_d = rd_sync1_q;
    rd_hist_d  = rd_sync2_q;
    wr_end     = wr_hist_q & ~wr_sync2_q;
    rd_end     = rd_hist_q & ~rd_sync2_q;
  end

  always_comb begin
    state_d         = state_q;
    read_addr_d     = read_addr_q;
    mem_addr_d      = mem_addr_q;
    data_reg_d      = data_reg_q;
    auto_inc_d      = auto_inc_q;
    data_valid_d    = data_valid_q;
    fetch_pending_d = fetch_pending_q;
    addr_commit     = wr_end && (mpuRegisterSelect <= 3'd2);

    case (state_q)
      IDLE, VALID: begin
        if (fetch_pending_q) begin
          state_d         = FETCH;
          fetch_pending_d = 1'b0;
          mem_addr_d      = read_addr_q;
        end
      end
      FETCH: begin
        // A byte for an address that changed mid-flight is stale; drop it and refetch from IDLE.
        if (memoryReadComplete) begin
          if (fetch_pending_q || addr_commit) begin
            state_d = IDLE;
          end else begin
            data_reg_d   = memoryReadData;
            data_valid_d = 1'b1;
            state_d      = VALID;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_end) begin
      case (mpuRegisterSelect)
        3'd0: read_addr_d[7:0] = mpuDataIn[7:0];
        3'd1: read_addr_d[8] = mpuDataIn[0];
        3'd2: read_addr_d[ADDR_WIDTH-1:9] = mpuDataIn[ADDR_WIDTH-10:0];
        3'd4: auto_inc_d = mpuDataIn[0];
        default: ;
      endcase
      if (addr_commit) begin
        data_valid_d    = 1'b0;
        fetch_pending_d = 1'b1;
      end
    end

    if (rd_end && (mpuRegisterSelect == 3'd3) && (state_q == VALID) && auto_inc_q) begin
      read_addr_d     = read_addr_q + ADDR_WIDTH'(1);
      data_valid_d    = 1'b0;
      fetch_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_sync1_q      <= 1'b0;
      wr_sync2_q      <= 1'b0;
      wr_hist_q       <= 1'b0;
      rd_sync1_q      <= 1'b0;
      rd_sync2_q      <= 1'b0;
      rd_hist_q       <= 1'b0;
      state_q         <= IDLE;
      read_addr_q     <= '0;
      mem_addr_q      <= '0;
      data_reg_q      <= '0;
      auto_inc_q      <= 1'b0;
      data_valid_q    <= 1'b0;
      fetch_pending_q <= 1'b0;
    end else begin
      wr_sync1_q      <= wr_sync1_d;
      wr_sync2_q      <= wr_sync2_d;
      wr_hist_q       <= wr_hist_d;
      rd_sync1_q      <= rd_sync1_d;
      rd_sync2_q      <= rd_sync2_d;
      rd_hist_q       <= rd_hist_d;
      state_q         <= state_d;
      read_addr_q     <= read_addr_d;
      mem_addr_q      <= mem_addr_d;
      data_reg_q      <= data_reg_d;
      auto_inc_q      <= auto_inc_d;
      data_valid_q    <= data_valid_d;
      fetch_pending_q <= fetch_pending_d;
    end
  end

`ifdef MCU_READBACK_STATUS_EN
  logic fetch_busy;
  assign fetch_busy = (state_q == FETCH) || fetch_pending_q;
`endif

  always_comb begin
    mpuDataOut = '0;
    case (mpuRegisterSelect)
      3'd0: mpuDataOut = DATA_WIDTH'(read_addr_q[7:0]);
      3'd1: mpuDataOut = DATA_WIDTH'(read_addr_q[8]);
      3'd2: mpuDataOut = DATA_WIDTH'(read_addr_q[ADDR_WIDTH-1:9]);
      3'd3: mpuDataOut = data_reg_q;
      3'd4: mpuDataOut = DATA_WIDTH'(auto_inc_q);
`ifdef MCU_READBACK_STATUS_EN
      3'd5: mpuDataOut = DATA_WIDTH'({fetch_busy, data_valid_q});
`else
      3'd5: mpuDataOut = '0;
`endif
      default: mpuDataOut = '0;
    endcase
  end

  // Raw strobe drives the bus so the MCU sees data without synchronizer latency.
  assign mpuDataOutEnable  = read_strobe & ~reset;
  assign memoryReadRequest = (state_q == FETCH);
  assign memoryAddress     = mem_addr_q;

endmodule
